// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared types for the memory-stage data responder
package data_memory_responder_pkg;

  localparam int BYTE_LANES = 4;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  write;
    logic [31:0]           address;
    logic [DATA_WIDTH-1:0] writeData;
    logic [BYTE_LANES-1:0] byteEnable;
  } memory_request_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] readData;
    logic                  error;
  } memory_response_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } memory_responder_state_t;

endpackage

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - single-port word RAM with byte-lane writes and registered read
module data_memory_array
  import data_memory_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clock,
  input  logic                     enable,
  input  logic                     write,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [BYTE_LANES-1:0]    byte_enable,
  output logic [DATA_WIDTH-1:0]    read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  // read_data only moves on an enabled load, so it holds through the response phase
  always_ff @(posedge clock) begin
    if (enable) begin
      if (write) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
          if (byte_enable[i]) begin
            mem[address][8*i +: 8] <= write_data[8*i +: 8];
          end
        end
      end else begin
        read_data <= mem[address];
      end
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - target side of the memory-stage load/store handshake
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int LATENCY       = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  requestValid,
  output logic                  requestReady,
  input  logic                  requestWrite,
  input  logic [31:0]           requestAddress,
  input  logic [DATA_WIDTH-1:0] requestWriteData,
  input  logic [BYTE_LANES-1:0] requestByteEnable,
  output logic                  responseValid,
  input  logic                  responseReady,
  output logic [DATA_WIDTH-1:0] responseReadData,
  output logic                  responseError,
  output logic                  busy
);

  memory_responder_state_t state, next_state;
  memory_request_t         incoming, request_q, commit_request;
  memory_response_t        response;
  logic [3:0]              wait_count;
  logic                    accept, commit, commit_error;
  logic [DATA_WIDTH-1:0]   array_read_data;

  function automatic logic request_error(input memory_request_t r);
    return (r.address[31:ADDRESS_WIDTH+2] != '0) ||
           (r.write && (r.byteEnable == '0)) ||
           (!r.write && (r.address[1:0] != 2'b00));
  endfunction

  assign incoming = '{write:      requestWrite,
                      address:    requestAddress,
                      writeData:  requestWriteData,
                      byteEnable: requestByteEnable};

  assign accept = requestValid && requestReady;

  // With zero latency the accept edge is also the commit edge, so commit from the live inputs
  assign commit_request = (state == IDLE) ? incoming : request_q;
  assign commit_error   = request_error(commit_request);
  assign commit = !reset &&
                  ((accept && (LATENCY == 0)) || ((state == WAIT) && (wait_count == 4'd1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_count <= 4'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        request_q  <= incoming;
        wait_count <= 4'(LATENCY);
      end else if (state == WAIT) begin
        wait_count <= wait_count - 4'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) next_state = (LATENCY == 0) ? RESPOND : WAIT;
      end
      WAIT: begin
        if (wait_count == 4'd1) next_state = RESPOND;
      end
      RESPOND: begin
        if (responseReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  data_memory_array #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_array (
    .clock      (clock),
    .enable     (commit && !commit_error),
    .write      (commit_request.write),
    .address    (commit_request.address[ADDRESS_WIDTH+1:2]),
    .write_data (commit_request.writeData),
    .byte_enable(commit_request.byteEnable),
    .read_data  (array_read_data)
  );

  always_comb begin
    response.error    = (state == RESPOND) && request_error(request_q);
    response.readData = '0;
    if ((state == RESPOND) && !request_q.write && !response.error) begin
      response.readData = array_read_data;
    end
  end

  assign requestReady     = (state == IDLE);
  assign responseValid    = (state == RESPOND);
  assign busy             = (state != IDLE);
  assign responseReadData = response.readData;
  assign responseError    = response.error;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed and randomized checks against a word-array model
module tb_data_memory_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // LATENCY=2 instance
  logic        reset;
  logic        request_valid, request_ready, request_write;
  logic [31:0] request_address, request_write_data;
  logic [3:0]  request_byte_enable;
  logic        response_valid, response_ready, response_error, busy;
  logic [31:0] response_read_data;

  // LATENCY=0 instance
  logic        z_request_valid, z_request_ready, z_request_write;
  logic [31:0] z_request_address, z_request_write_data;
  logic [3:0]  z_request_byte_enable;
  logic        z_response_valid, z_response_ready, z_response_error, z_busy;
  logic [31:0] z_response_read_data;

  data_memory_responder #(.ADDRESS_WIDTH(10), .LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .requestValid(request_valid), .requestReady(request_ready),
    .requestWrite(request_write), .requestAddress(request_address),
    .requestWriteData(request_write_data), .requestByteEnable(request_byte_enable),
    .responseValid(response_valid), .responseReady(response_ready),
    .responseReadData(response_read_data), .responseError(response_error),
    .busy(busy)
  );

  data_memory_responder #(.ADDRESS_WIDTH(10), .LATENCY(0)) dut_zero (
    .clock(clock), .reset(reset),
    .requestValid(z_request_valid), .requestReady(z_request_ready),
    .requestWrite(z_request_write), .requestAddress(z_request_address),
    .requestWriteData(z_request_write_data), .requestByteEnable(z_request_byte_enable),
    .responseValid(z_response_valid), .responseReady(z_response_ready),
    .responseReadData(z_response_read_data), .responseError(z_response_error),
    .busy(z_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [1024];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic model_error(input logic wr, input logic [31:0] addr, input logic [3:0] be);
    return (addr[31:12] != 0) || (wr && be == 0) || (!wr && addr[1:0] != 0);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One full transaction on the LATENCY=2 instance, holding responseReady low for `hold` cycles
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, input string tag);
    logic        exp_err;
    logic [31:0] exp_data;
    int          idx;
    int          lat;
    exp_err  = model_error(wr, addr, be);
    idx      = int'(addr[11:2]);
    exp_data = (wr || exp_err) ? 32'h0 : model_mem[idx];
    if (wr && !exp_err) model_mem[idx] = merge(model_mem[idx], wdata, be);

    @(negedge clock);
    check({tag, " ready_before"}, {31'h0, request_ready}, 32'h1);
    request_valid       = 1'b1;
    request_write       = wr;
    request_address     = addr;
    request_write_data  = wdata;
    request_byte_enable = be;
    @(posedge clock);
    @(negedge clock);
    request_valid       = 1'b0;
    request_write       = 1'($urandom);
    request_address     = $urandom;
    request_write_data  = $urandom;
    request_byte_enable = 4'($urandom);
    check({tag, " busy_after_accept"}, {31'h0, busy}, 32'h1);
    check({tag, " ready_after_accept"}, {31'h0, request_ready}, 32'h0);
    lat = 1;
    while (!response_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " data"}, response_read_data, exp_data);
    check({tag, " error"}, {31'h0, response_error}, {31'h0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check({tag, " hold_valid"}, {31'h0, response_valid}, 32'h1);
      check({tag, " hold_data"}, response_read_data, exp_data);
      check({tag, " hold_error"}, {31'h0, response_error}, {31'h0, exp_err});
      check({tag, " hold_ready"}, {31'h0, request_ready}, 32'h0);
      check({tag, " hold_busy"}, {31'h0, busy}, 32'h1);
    end
    response_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    response_ready = 1'b0;
    check({tag, " retired_valid"}, {31'h0, response_valid}, 32'h0);
    check({tag, " retired_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] z_data [4];
    logic        z_wr;
    int          z_idx, z_resp, word, kind;
    logic [31:0] addr;

    reset = 1'b1;
    request_valid = 1'b0; request_write = 1'b0; request_address = '0;
    request_write_data = '0; request_byte_enable = '0; response_ready = 1'b0;
    z_request_valid = 1'b0; z_request_write = 1'b0; z_request_address = '0;
    z_request_write_data = '0; z_request_byte_enable = '0; z_response_ready = 1'b0;
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_ready", {31'h0, request_ready}, 32'h1);
    check("reset_valid", {31'h0, response_valid}, 32'h0);
    check("reset_data", response_read_data, 32'h0);
    check("reset_error", {31'h0, response_error}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_z_ready", {31'h0, z_request_ready}, 32'h1);
    check("reset_z_busy", {31'h0, z_busy}, 32'h0);
    reset = 1'b0;

    // Directed: full word, partial lane, error cases, stall
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "t1_store");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "t1_load");
    txn(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, "t2_store");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "t2_load");
    txn(1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, "t3_oor_load");
    txn(1'b1, 32'h10, 32'h11223344, 4'h0, 0, "t3_be0_store");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "t3_load_unchanged");
    txn(1'b0, 32'h12, 32'h0, 4'h0, 0, "t3_misaligned");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, "t4_stall");

    // Reset lands on what would have been the commit edge of a store
    txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, "t5_prefill");
    @(negedge clock);
    request_valid = 1'b1; request_write = 1'b1; request_address = 32'h20;
    request_write_data = 32'h12345678; request_byte_enable = 4'hF;
    @(posedge clock);
    @(negedge clock);
    request_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("t5_ready", {31'h0, request_ready}, 32'h1);
    check("t5_valid", {31'h0, response_valid}, 32'h0);
    check("t5_data", response_read_data, 32'h0);
    check("t5_error", {31'h0, response_error}, 32'h0);
    check("t5_busy", {31'h0, busy}, 32'h0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, "t5_load");

    // Randomized traffic over a small word window
    for (int w = 64; w < 72; w++) txn(1'b1, 32'(w) << 2, $urandom, 4'hF, 0, "rnd_prefill");
    for (int n = 0; n < 40; n++) begin
      word = 64 + int'($urandom_range(0, 7));
      addr = 32'(word) << 2;
      kind = int'($urandom_range(0, 9));
      if (kind < 3)
        txn(1'b1, addr, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 2)), "rnd_store");
      else if (kind < 6)
        txn(1'b0, addr, $urandom, 4'($urandom), int'($urandom_range(0, 2)), "rnd_load");
      else if (kind == 6)
        txn(1'($urandom), addr | (32'h1 << $urandom_range(12, 31)), $urandom, 4'hF, 0, "rnd_oor");
      else if (kind == 7)
        txn(1'b1, addr, $urandom, 4'h0, 0, "rnd_be0");
      else if (kind == 8)
        txn(1'b0, addr | 32'($urandom_range(1, 3)), $urandom, 4'h0, 0, "rnd_misaligned");
      else
        txn(1'b0, addr, $urandom, 4'h0, 1, "rnd_load_hold");
    end

    // Zero-latency instance: requests and response acceptance held high back to back
    for (int i = 0; i < 4; i++) z_data[i] = $urandom;
    z_response_ready = 1'b1;
    z_idx  = 0;
    z_resp = 0;
    @(negedge clock);
    z_request_valid = 1'b1; z_request_write = 1'b1; z_request_address = 32'h0;
    z_request_write_data = z_data[0]; z_request_byte_enable = 4'hF;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clock);
      check("t6_resp_valid", {31'h0, z_response_valid}, 32'(cyc % 2));
      check("t6_req_ready", {31'h0, z_request_ready}, 32'((cyc + 1) % 2));
      if (z_response_valid) begin
        check("t6_data", z_response_read_data, (z_resp < 4) ? 32'h0 : z_data[z_resp - 4]);
        check("t6_error", {31'h0, z_response_error}, 32'h0);
        z_resp++;
      end
      if (z_request_ready) begin
        z_idx++;
        if (z_idx < 8) begin
          z_wr = (z_idx < 4);
          z_request_write      = z_wr;
          z_request_address    = 32'(z_idx % 4) << 2;
          z_request_write_data = z_wr ? z_data[z_idx % 4] : $urandom;
        end else begin
          z_request_valid = 1'b0;
        end
      end
    end
    check("t6_response_count", 32'(z_resp), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
